// File: rtl/uart_pkg.sv
// Shared definitions for the 128-bit UART word receiver.
// Optional even-parity support is enabled by defining UART_WORD_RX_PARITY_EN.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 434;              // 50 MHz / 115200
  localparam int WORD_BYTES_DEF   = 16;               // frames per word
  localparam int WORD_W_DEF       = 8 * WORD_BYTES_DEF;
  localparam int TIMEOUT_BITS_DEF = 20;               // idle bit-times tolerated between frames

  // Receiver states. The byte engine walks IDLE/START/DATA/PARITY/STOP/BREAK;
  // GAP is the word-level view of "byte engine idle with a partial word held".
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    GAP,
    BREAK
  } rx_state_e;

  // True when data plus parity bit hold an even number of ones.
  function automatic logic even_parity_ok(input logic [7:0] data, input logic par);
    return ~(^{data, par});
  endfunction

endpackage

// File: rtl/uart_rx_byte_fsm.sv
// Single-frame UART receiver: synchroniser, start-bit glitch rejection and
// mid-bit sampling of data, optional parity and stop bits.
// Frame format is 8N1, or 8E1 when UART_WORD_RX_PARITY_EN is defined.
// byte_valid / frame_err / parity_err / start_ok are single-cycle strobes
// decoded from the current state so the word level can register them.
module uart_rx_byte_fsm
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_serial,
  output logic       start_ok,
  output logic       frame_active,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       data_sr, data_sr_nxt;
  logic             rx_meta, rx_sync;
`ifdef UART_WORD_RX_PARITY_EN
  logic             par_bit, par_bit_nxt;
`endif

  // Two-flop synchroniser; resets high so reset looks like an idle line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      // NOTE: clocked state uses non-blocking assignment so every flop samples pre-edge values.
      rx_meta <= rx_serial;
      rx_sync <= rx_meta;
    end
  end

  // State, bit-timing counter and data shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      data_sr <= '0;
`ifdef UART_WORD_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      data_sr <= data_sr_nxt;
`ifdef UART_WORD_RX_PARITY_EN
      par_bit <= par_bit_nxt;
`endif
    end
  end

  // Next-state and strobe decode; all sampling is at the mid-bit count.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    data_sr_nxt = data_sr;
`ifdef UART_WORD_RX_PARITY_EN
    par_bit_nxt = par_bit;
`endif
    start_ok    = 1'b0;
    byte_valid  = 1'b0;
    frame_err   = 1'b0;
    parity_err  = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_sync) state_nxt = START;
      end

      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt = '0;
          if (!rx_sync) begin
            state_nxt   = DATA;
            bit_idx_nxt = '0;
            start_ok    = 1'b1;
          end else begin
            // Line went back high before mid start bit: a glitch, drop it silently.
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt     = '0;
          data_sr_nxt = {rx_sync, data_sr[7:1]};   // LSB arrives first
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_WORD_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

`ifdef UART_WORD_RX_PARITY_EN
      PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt     = '0;
          par_bit_nxt = rx_sync;
          state_nxt   = STOP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`endif

      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (!rx_sync) begin
            // Low stop bit outranks a parity mismatch; wait out the low line.
            frame_err = 1'b1;
            state_nxt = BREAK;
          end else begin
            state_nxt = IDLE;
`ifdef UART_WORD_RX_PARITY_EN
            if (!even_parity_ok(data_sr, par_bit)) parity_err = 1'b1;
            else                                   byte_valid = 1'b1;
`else
            byte_valid = 1'b1;
`endif
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      BREAK: begin
        // A line held low must not retrigger START; wait for it to return high.
        cnt_nxt = '0;
        if (rx_sync) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign rx_byte      = data_sr;
  assign frame_active = (state == DATA) || (state == PARITY) || (state == STOP);

endmodule

// File: rtl/uart_word_rx.sv
// 128-bit UART word receiver: assembles WORD_BYTES back-to-back frames into
// one word, strobes o_rx_dv when complete, and aborts partial words on a
// framing error, parity error or an over-long gap between frames.
// Define UART_WORD_RX_PARITY_EN for 8E1 frames; otherwise 8N1 and
// o_parity_err is tied low.
module uart_word_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEF,
  parameter int WORD_BYTES   = uart_pkg::WORD_BYTES_DEF,
  parameter int TIMEOUT_BITS = uart_pkg::TIMEOUT_BITS_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_rx_serial,
  output logic                    o_rx_dv,
  output logic [8*WORD_BYTES-1:0] o_rx_word,
  output logic                    o_rx_busy,
  output logic                    o_frame_err,
  output logic                    o_timeout_err,
  output logic                    o_parity_err
);

  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int IDX_W  = $clog2(WORD_BYTES);
  localparam int LIMIT  = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int GAP_W  = $clog2(LIMIT + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(LIMIT - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(LIMIT);

  logic             start_ok, frame_active, byte_valid, frame_err, parity_err;
  logic [7:0]       rx_byte;
  logic [IDX_W-1:0] byte_idx;
  logic [GAP_W-1:0] gap_cnt;
  logic [WORD_W-9:0] word_sr;   // bytes 0..WORD_BYTES-2; the last byte goes straight out
  logic             in_gap, timeout_hit, last_byte, word_done, word_abort;

  uart_rx_byte_fsm #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte_fsm (
    .clk          (i_clk),
    .rst_n        (i_rst_n),
    .rx_serial    (i_rx_serial),
    .start_ok     (start_ok),
    .frame_active (frame_active),
    .byte_valid   (byte_valid),
    .rx_byte      (rx_byte),
    .frame_err    (frame_err),
    .parity_err   (parity_err)
  );

  // GAP: a partial word is held and no frame is being shifted in.
  assign in_gap      = (byte_idx != '0) && !frame_active;
  assign timeout_hit = in_gap && (gap_cnt == GAP_LAST);
  assign last_byte   = (byte_idx == IDX_LAST);
  assign word_done   = byte_valid && last_byte;
  assign word_abort  = frame_err || parity_err || timeout_hit;

  // Inter-frame gap counter; saturates instead of wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                gap_cnt <= '0;
    else if (!in_gap)            gap_cnt <= '0;
    else if (gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + 1'b1;
  end

  // Word assembly shift register: each new byte enters at the top so byte 0
  // ends up in the low bits once the word is complete.
  // NOTE: pure datapath storage is left unreset; byte_idx guarantees it is fully rewritten before use.
  always_ff @(posedge i_clk) begin
    if (byte_valid) word_sr <= {rx_byte, word_sr[WORD_W-9:8]};
  end

  // Byte index, delivered word and the data-valid / error strobes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      byte_idx      <= '0;
      o_rx_dv       <= 1'b0;
      o_rx_word     <= '0;
      o_frame_err   <= 1'b0;
      o_timeout_err <= 1'b0;
    end else begin
      o_rx_dv       <= 1'b0;
      o_frame_err   <= frame_err;
      o_timeout_err <= timeout_hit;
      if (word_abort) begin
        byte_idx <= '0;                       // o_rx_word is never touched by an abort
      end else if (byte_valid) begin
        if (last_byte) begin
          byte_idx  <= '0;
          o_rx_word <= {rx_byte, word_sr};
          o_rx_dv   <= 1'b1;
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end
    end
  end

  // Busy rises once a start bit survives glitch rejection and stays up
  // across inter-frame gaps until the word completes or is aborted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                       o_rx_busy <= 1'b0;
    else if (start_ok)                  o_rx_busy <= 1'b1;
    else if (word_done || word_abort)   o_rx_busy <= 1'b0;
  end

`ifdef UART_WORD_RX_PARITY_EN
  // Registered parity-mismatch strobe, aligned with the other error strobes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_parity_err <= 1'b0;
    else          o_parity_err <= parity_err;
  end
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_word_rx.sv
// Self-checking bench for uart_word_rx (8N1, or 8E1 with UART_WORD_RX_PARITY_EN).
// A short bit time keeps whole 16-frame words cheap to simulate.
module tb_uart_word_rx;

  localparam int CPB     = 16;
  localparam int NB      = 16;
  localparam int TO_BITS = 20;
  localparam int HALF    = CPB / 2;
  localparam int LIMIT   = TO_BITS * CPB;
`ifdef UART_WORD_RX_PARITY_EN
  localparam bit PAR      = 1'b1;
  localparam int STOP_OFS = 10 * CPB;
`else
  localparam bit PAR      = 1'b0;
  localparam int STOP_OFS = 9 * CPB;
`endif
  // Start-bit edge on the raw line to registered stop-bit outcome:
  // 2 synchroniser clocks, 1 to leave IDLE, half a bit to mid start,
  // whole bits to mid stop.
  localparam int LAT = 3 + HALF + STOP_OFS;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           serial;
  logic           dv, busy, fe, te, pe;
  logic [8*NB-1:0] word;

  always #5 clk = ~clk;

  uart_word_rx #(
    .CLKS_PER_BIT (CPB),
    .WORD_BYTES   (NB),
    .TIMEOUT_BITS (TO_BITS)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_rx_serial   (serial),
    .o_rx_dv       (dv),
    .o_rx_word     (word),
    .o_rx_busy     (busy),
    .o_frame_err   (fe),
    .o_timeout_err (te),
    .o_parity_err  (pe)
  );

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard of expected words and the cycle each should appear on.
  typedef struct {
    logic [127:0] word;
    int           cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int   dv_cnt, fe_cnt, to_cnt, pe_cnt, busy_rise, to_cyc;
  logic busy_q = 1'b0;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (busy && !busy_q) busy_rise++;
    busy_q = busy;
    if (fe) fe_cnt++;
    if (pe) pe_cnt++;
    if (te) begin
      to_cnt++;
      to_cyc = cyc;
    end
    if (dv) begin
      dv_cnt++;
      check("sb_pending", 128'(sb.size() != 0), 128'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rx_word", word, e.word);
        check("dv_cycle", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  task automatic clear_counts();
    dv_cnt = 0; fe_cnt = 0; to_cnt = 0; pe_cnt = 0; busy_rise = 0; to_cyc = -1;
  endtask

  // Drive one bit for CPB clocks; always entered and left at posedge+1.
  task automatic drive_bit(input logic v);
    serial = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip,
                            output int k);
    k = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PAR) drive_bit((^b) ^ par_flip);
    drive_bit(stop_v);
  endtask

  task automatic send_word(input logic [127:0] data, input int n, input int bad_stop,
                           input int bad_par, input bit exp_dv, output int k_last);
    for (int f = 0; f < n; f++) begin
      if (f == n - 1 && exp_dv) sb.push_back('{data, cyc + LAT});
      send_frame(data[8*f +: 8], 1'(f != bad_stop), 1'(f == bad_par), k_last);
    end
    serial = 1'b1;
  endtask

  typedef struct {
    logic [127:0] data;
    int           n_frames;
    int           bad_stop;
    int           bad_par;
    bit           glitch;
    bit           exp_dv;
    bit           exp_fe;
    bit           exp_to;
    bit           exp_pe;
  } vec_t;

  vec_t         vecs[8];
  vec_t         v;
  int           n_vec;
  int           k_last;
  logic [127:0] model_word;
  logic [127:0] part_word;

  initial begin
    rst_n  = 1'b0;
    serial = 1'b1;
    clear_counts();
    model_word = '0;

    vecs[0] = '{128'h00112233445566778899AABBCCDDEEFF, 16, -1, -1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, 16, -1, -1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{128'h11111111_22222222_33333333_44444444, 6, 5, -1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{128'h0F0E0D0C0B0A09080706050403020100, 16, -1, -1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{128'h89ABCDEF_01234567_76543210_FEDCBA98, 7, -1, -1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{128'h0123456789ABCDEF_FEDCBA9876543210, 16, -1, -1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    n_vec = 6;
`ifdef UART_WORD_RX_PARITY_EN
    vecs[6] = '{128'h55AA55AA_0F1E2D3C_4B5A6978_8796A5B4, 4, -1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{128'hC0FFEE00_13579BDF_02468ACE_F1E2D3C4, 16, -1, -1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    n_vec = 8;
`endif

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_strobes", {dv, busy, fe, te, pe}, 5'b0);
    check("reset_word", word, 128'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Table-driven words.
    for (int i = 0; i < n_vec; i++) begin
      v = vecs[i];
      clear_counts();
      if (v.glitch) begin
        serial = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        serial = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;
        check($sformatf("v%0d_glitch_busy", i), 128'(busy_rise), 128'd0);
        check($sformatf("v%0d_glitch_err", i), 128'(fe_cnt + to_cnt + pe_cnt), 128'd0);
      end
      send_word(v.data, v.n_frames, v.bad_stop, v.bad_par, v.exp_dv, k_last);
      repeat (LIMIT + 4 * CPB) @(posedge clk);
      #1;
      if (v.exp_dv) model_word = v.data;
      check($sformatf("v%0d_dv_cnt", i), 128'(dv_cnt), 128'(v.exp_dv));
      check($sformatf("v%0d_fe_cnt", i), 128'(fe_cnt), 128'(v.exp_fe));
      check($sformatf("v%0d_to_cnt", i), 128'(to_cnt), 128'(v.exp_to));
      check($sformatf("v%0d_pe_cnt", i), 128'(pe_cnt), 128'(v.exp_pe));
      check($sformatf("v%0d_busy_rise", i), 128'(busy_rise), 128'd1);
      check($sformatf("v%0d_busy_end", i), 128'(busy), 128'd0);
      check($sformatf("v%0d_word_hold", i), word, model_word);
      check($sformatf("v%0d_sb_empty", i), 128'(sb.size()), 128'd0);
      if (v.exp_to)
        check($sformatf("v%0d_to_cycle", i), 128'(to_cyc), 128'(k_last + LAT + LIMIT));
    end

    // Reset asserted in the middle of frame 10.
    clear_counts();
    part_word = 128'hFFEEDDCCBBAA99887766554433221100;
    for (int f = 0; f < 10; f++) send_frame(part_word[8*f +: 8], 1'b1, 1'b0, k_last);
    serial = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    #1;
    check("rst_busy_before", 128'(busy), 128'd1);
    rst_n = 1'b0;
    #1;
    check("rst_strobes_now", {dv, busy, fe, te, pe}, 5'b0);
    check("rst_word_now", word, 128'd0);
    model_word = '0;
    serial = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (LIMIT + 2 * CPB) @(posedge clk);
    #1;
    check("rst_no_pulses", 128'(dv_cnt + fe_cnt + to_cnt + pe_cnt), 128'd0);

    clear_counts();
    send_word(128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5, 16, -1, -1, 1'b1, k_last);
    repeat (4 * CPB) @(posedge clk);
    #1;
    model_word = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;
    check("post_rst_dv_cnt", 128'(dv_cnt), 128'd1);
    check("post_rst_errs", 128'(fe_cnt + to_cnt + pe_cnt), 128'd0);
    check("post_rst_word", word, model_word);
    check("post_rst_busy_rise", 128'(busy_rise), 128'd1);
    check("post_rst_sb_empty", 128'(sb.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
